// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, branch redirect
// and the IF/ID hand-off to decode. The fetch stage is the master side.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one request in flight
// to instruction memory and holds the returned word in a one-entry IF/ID
// register. Redirects squash the in-flight response via the kill flag.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.master bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic            kill;
  logic            id_valid_q;
  logic [31:0]     id_instr_q;
  logic [XLEN-1:0] id_pc_q;

  logic            req;
  logic            grant;
  logic            load;
  logic            consume;
  logic [XLEN-1:0] redirect_target;

  // Request only when the IF/ID slot is guaranteed free by the time the
  // response can arrive, so a response never has to be stalled.
  assign req     = (state == S_FETCH) && (!id_valid_q || bus.id_ready) && !rst;
  assign grant   = req && bus.imem_gnt;
  assign load    = (state == S_WAIT) && bus.imem_rvalid && !kill && !bus.redirect_valid;
  assign consume = id_valid_q && bus.id_ready;
  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // Single state register: FSM, PC, kill flag and IF/ID slot; redirect last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      kill       <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments let later statements in this block
      // override earlier ones (redirect over grant/load) without ordering races.
      unique case (state)
        S_FETCH: begin
          if (grant) begin
            state   <= S_WAIT;
            pend_pc <= pc;
            pc      <= pc + XLEN'(4);
          end
        end
        S_WAIT: begin
          // A response in FETCH would be a protocol error; only WAIT listens.
          if (bus.imem_rvalid) begin
            state <= S_FETCH;
            kill  <= 1'b0;
          end
        end
      endcase

      if (load) begin
        id_valid_q <= 1'b1;
        id_instr_q <= bus.imem_rdata;
        id_pc_q    <= pend_pc;
      end else if (consume) begin
        id_valid_q <= 1'b0;
      end

      if (bus.redirect_valid) begin
        pc         <= redirect_target;
        id_valid_q <= 1'b0;
        // Anything granted but not yet returned belongs to the squashed path.
        if (grant || (state == S_WAIT && !bus.imem_rvalid)) begin
          kill <= 1'b1;
        end
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  // Pure slice so the control unit sees the opcode in the same cycle as id_instr.
  assign bus.id_opcode = id_instr_q[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level model that
// tracks the PC, a queue of outstanding fetches and the IF/ID slot.
module tb_fetch_stage;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_stage_if #(.XLEN(XLEN)) bus ();

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef struct {
    logic [31:0] addr;
    bit          dead;
  } fetch_t;

  fetch_t      outq[$];
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_slot_pc;

  int n_vec = 0;
  int n_err = 0;

  // Snapshot of the DUT outputs seen by the most recent step.
  logic [31:0] obs_req, obs_addr, obs_valid, obs_instr, obs_pc, obs_opcode;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the model, then advance the model across the rising edge.
  task automatic step(input bit r, input bit g, input bit v, input bit rdy,
                      input bit rd, input logic [31:0] rpc, input bit chk = 1'b1);
    bit          exp_req;
    bit          resp;
    bit          loaded;
    logic [31:0] data;
    logic [31:0] resp_addr;
    @(negedge clk);
    rst                = r;
    bus.imem_gnt       = g;
    bus.imem_rvalid    = v;
    bus.id_ready       = rdy;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    data               = (outq.size() > 0) ? (outq[0].addr | 32'h13) : 32'hDEAD_BEEF;
    bus.imem_rdata     = data;
    #1;
    exp_req = !r && (outq.size() == 0) && (!m_valid || rdy);
    obs_req    = 32'(bus.imem_req);
    obs_addr   = bus.imem_addr;
    obs_valid  = 32'(bus.id_valid);
    obs_instr  = bus.id_instr;
    obs_pc     = bus.id_pc;
    obs_opcode = 32'(bus.id_opcode);
    if (chk) begin
      check("imem_req",  obs_req,    32'(exp_req));
      check("imem_addr", obs_addr,   m_pc);
      check("id_valid",  obs_valid,  32'(m_valid));
      check("id_instr",  obs_instr,  m_instr);
      check("id_pc",     obs_pc,     m_slot_pc);
      check("id_opcode", obs_opcode, 32'(m_instr[6:0]));
    end
    @(posedge clk);
    if (r) begin
      m_pc      = RESET_PC;
      m_valid   = 1'b0;
      m_instr   = NOP_INSTR;
      m_slot_pc = '0;
      outq.delete();
    end else begin
      resp      = (outq.size() > 0) && v;
      loaded    = 1'b0;
      resp_addr = '0;
      if (resp) begin
        loaded    = !outq[0].dead && !rd;
        resp_addr = outq[0].addr;
        void'(outq.pop_front());
      end
      if (exp_req && g) begin
        outq.push_back('{addr: m_pc, dead: rd});
        m_pc = m_pc + 32'd4;
      end
      if (loaded) begin
        m_valid   = 1'b1;
        m_instr   = data;
        m_slot_pc = resp_addr;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (rd) begin
        m_pc    = rpc & ~32'h3;
        m_valid = 1'b0;
        foreach (outq[i]) outq[i].dead = 1'b1;
      end
    end
  endtask

  // Zero-wait memory: grant whenever asked, respond the cycle after grant.
  task automatic zw(input bit rdy);
    step(1'b0, 1'b1, outq.size() > 0, rdy, 1'b0, '0);
  endtask

  initial begin
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    m_pc      = RESET_PC;
    m_valid   = 1'b0;
    m_instr   = NOP_INSTR;
    m_slot_pc = '0;

    // Reset: first cycle unchecked (registers still unknown), second checked.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("rst_req", obs_req, 32'd0);
    check("rst_addr", obs_addr, RESET_PC);

    // Zero-wait streaming: addresses 0,4,8; first id_valid two cycles after grant.
    zw(1'b1);
    check("seq_addr0", obs_addr, 32'h0);
    zw(1'b1);
    zw(1'b1);
    check("first_valid", obs_valid, 32'd1);
    check("first_pc", obs_pc, 32'h0);
    check("first_opcode", obs_opcode, 32'h13);
    check("seq_addr1", obs_addr, 32'h4);
    zw(1'b1);
    zw(1'b1);
    check("seq_addr2", obs_addr, 32'h8);
    zw(1'b1);
    zw(1'b1);

    // Back-pressure: hold id_ready low for 5 cycles after the first load.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    zw(1'b1);
    zw(1'b1);
    for (int i = 0; i < 5; i++) begin
      zw(1'b0);
      check("stall_req", obs_req, 32'd0);
      check("stall_instr", obs_instr, 32'h13);
      check("stall_pc", obs_pc, 32'h0);
    end
    zw(1'b1);
    check("release_addr", obs_addr, 32'h4);
    check("release_req", obs_req, 32'd1);
    zw(1'b1);
    zw(1'b1);

    // Redirect during WAIT; the squashed response arrives 3 cycles later.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h102);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("kill_wait_req", obs_req, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("kill_valid", obs_valid, 32'd0);
    check("kill_req", obs_req, 32'd1);
    check("kill_addr", obs_addr, 32'h100);

    // Redirect coincident with imem_rvalid.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("rv_redir_valid", obs_valid, 32'd0);
    check("rv_redir_req", obs_req, 32'd1);
    check("rv_redir_addr", obs_addr, 32'h200);

    // Redirect coincident with grant.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("gnt_redir_wait", obs_req, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("gnt_redir_valid", obs_valid, 32'd0);
    check("gnt_redir_addr", obs_addr, 32'h300);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("gnt_redir_load", obs_valid, 32'd1);
    check("gnt_redir_pc", obs_pc, 32'h300);
    check("gnt_redir_instr", obs_instr, 32'h313);

    // One-cycle reset while in WAIT, followed by a stray response.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("rst_wait_req", obs_req, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("post_rst_req", obs_req, 32'd1);
    check("post_rst_addr", obs_addr, RESET_PC);
    check("post_rst_valid", obs_valid, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("stray_ignored", obs_valid, 32'd0);
    check("stray_req", obs_req, 32'd1);

    // PC wrap from 0xFFFF_FFFC; low redirect bits are ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("wrap_top_addr", obs_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("wrap_addr", obs_addr, 32'h0);
    check("wrap_pc", obs_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Random traffic: variable grant/response latency, stalls, redirects, resets.
    for (int i = 0; i < 800; i++) begin
      bit          r, g, v, rdy, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(99) == 0);
      g   = ($urandom_range(9) < 7);
      v   = (outq.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0);
      rdy = ($urandom_range(9) < 7);
      rd  = ($urandom_range(99) < 8);
      rpc = $urandom();
      step(r, g, v, rdy, rd, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
